uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to add the PAR_EN/PAR_TYP ports and the PARITY state.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic [5:0]            prescale,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [5:0]              bit_cnt;
  logic [5:0]              p_reg;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    bit_last;
  logic                    data_last;
  logic                    data_step;
  logic                    tx_next;
  logic                    busy_next;
`ifdef UART_TX_PARITY_EN
  logic                    par_en_q;
  logic                    par_bit_q;
`endif

  assign bit_last  = (bit_cnt == p_reg - 6'd1);
  assign data_last = (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      TX_OUT <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= next_state;
      TX_OUT <= tx_next;
      busy   <= busy_next;
    end
  end

  always_comb begin
    // NOTE: assigning a default first means no path leaves next_state unassigned, so no latch.
    next_state = state;
    case (state)
      IDLE:  if (DATA_VALID) next_state = START;
      START: if (bit_last) next_state = DATA;
      DATA: begin
        if (bit_last && data_last) begin
`ifdef UART_TX_PARITY_EN
          next_state = par_en_q ? PARITY : STOP;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_last) next_state = STOP;
`endif
      STOP:  if (bit_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and registered, so the line never glitches.
  always_comb begin
    data_step = (next_state == DATA) && ((state != DATA) || bit_last);
    busy_next = (next_state != IDLE);
    tx_next   = TX_OUT;
    case (next_state)
      IDLE, STOP: tx_next = 1'b1;
      START:      tx_next = 1'b0;
      DATA:       if (data_step) tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:     tx_next = par_bit_q;
`endif
      default:    tx_next = 1'b1;
    endcase
  end

  // NOTE: the datapath is cleared by reset as well, so an aborted frame leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      p_reg     <= '0;
      idx       <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      if (DATA_VALID) begin
        shift_reg <= P_DATA;
        p_reg     <= (prescale < 6'd2) ? 6'd2 : prescale;
        idx       <= '0;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
`endif
      end
    end else begin
      bit_cnt <= bit_last ? 6'd0 : bit_cnt + 6'd1;
      // Bit 0 always holds the next data bit to put on the line.
      if (data_step) shift_reg <= shift_reg >> 1;
      if (state == DATA && bit_last) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model compared every cycle,
// plus directed frames with hand-computed bit sequences and lengths.
module tb_uart_tx;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_BUILD = 1'b1;
`else
  localparam bit PARITY_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic [5:0]    prescale = 6'd8;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          TX_OUT;
  logic          busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .prescale   (prescale),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
`endif
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of line levels, each repeated P times.
  bit   exp_q[$];
  logic exp_tx     = 1'b1;
  logic exp_busy   = 1'b0;
  bit   model_idle = 1'b1;
  bit   chk_en     = 1'b0;

  task automatic build_frame(input logic [DW-1:0] d, input logic [5:0] pre,
                             input bit pe, input bit pt);
    int p;
    bit seq[$];
    p = (pre < 6'd2) ? 2 : int'(pre);
    seq.push_back(1'b0);
    for (int i = 0; i < DW; i++) seq.push_back(d[i]);
    if (PARITY_BUILD && pe) seq.push_back((($countones(d) % 2) == 1) ^ pt);
    seq.push_back(1'b1);
    foreach (seq[i]) repeat (p) exp_q.push_back(seq[i]);
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_tx     = 1'b1;
      exp_busy   = 1'b0;
      model_idle = 1'b1;
      chk_en     = 1'b1;
    end else begin
      if (exp_q.size() == 0 && model_idle && DATA_VALID)
        build_frame(P_DATA, prescale, par_en, par_typ);
      if (exp_q.size() != 0) begin
        exp_tx     = exp_q.pop_front();
        exp_busy   = 1'b1;
        model_idle = 1'b0;
      end else begin
        exp_tx     = 1'b1;
        exp_busy   = 1'b0;
        model_idle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_out", TX_OUT, exp_tx);
      check("busy", busy, exp_busy);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("wait_idle", busy, 0);
  endtask

  // Sends one frame and checks its busy length and mid-bit samples against literals.
  task automatic send_frame(input logic [DW-1:0] d, input logic [5:0] pre, input bit pe,
                            input bit pt, input int nbits, input logic [15:0] exp_seq,
                            input int exp_len, input int chg_at, input string name);
    int          p;
    int          c;
    logic [15:0] seen;
    logic [15:0] mask;
    wait_idle();
    P_DATA = d; prescale = pre; par_en = pe; par_typ = pt; DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    p    = (pre < 6'd2) ? 2 : int'(pre);
    c    = 0;
    seen = '0;
    mask = 16'((32'd1 << nbits) - 1);
    while (busy === 1'b1 && c < 4000) begin
      if (c == chg_at) begin
        P_DATA = ~d; prescale = 6'd3; par_en = ~pe; par_typ = ~pt;
      end
      if ((c % p) == (p / 2) && (c / p) < 16) seen[c / p] = TX_OUT;
      c++;
      @(negedge clk);
    end
    check({name, "_len"}, c, exp_len);
    check({name, "_bits"}, seen & mask, exp_seq);
  endtask

  initial begin
    int run1;
    int gap;
    int run2;

    repeat (3) @(negedge clk);
    check("reset_tx", TX_OUT, 1);
    check("reset_busy", busy, 0);
    rst = 1'b1;

    // Sequences below are listed last-bit-first: bit 0 is the start bit.
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 10, 16'b1101001010, 80, -1, "a5_nopar");
`ifdef UART_TX_PARITY_EN
    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 11, 16'b10101001010, 88, -1, "a5_even");
    send_frame(8'hA5, 6'd8, 1'b1, 1'b1, 11, 16'b11101001010, 88, -1, "a5_odd");
`endif
    send_frame(8'h55, 6'd0, 1'b0, 1'b0, 10, 16'b1010101010, 20, -1, "p0");
    send_frame(8'h55, 6'd1, 1'b0, 1'b0, 10, 16'b1010101010, 20, -1, "p1");
    send_frame(8'h3C, 6'd8, 1'b0, 1'b0, 10, 16'b1001111000, 80, 19, "midchg");

    // Back-to-back frames with DATA_VALID held high.
    wait_idle();
    P_DATA = 8'h00; prescale = 6'd16; par_en = 1'b0; DATA_VALID = 1'b1;
    @(negedge clk);
    P_DATA = 8'hFF;
    run1 = 0;
    while (busy === 1'b1 && run1 < 1000) begin run1++; @(negedge clk); end
    gap = 0;
    while (busy === 1'b0 && gap < 10) begin gap++; @(negedge clk); end
    DATA_VALID = 1'b0;
    run2 = 0;
    while (busy === 1'b1 && run2 < 1000) begin run2++; @(negedge clk); end
    check("b2b_run1", run1, 160);
    check("b2b_gap", gap, 1);
    check("b2b_run2", run2, 160);

    // Reset during data bit 3, then a clean frame.
    wait_idle();
    P_DATA = 8'h3C; prescale = 6'd8; DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    repeat (33) @(negedge clk);
    rst = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge clk);
    check("abort_tx", TX_OUT, 1);
    check("abort_busy", busy, 0);
    rst = 1'b1;
    DATA_VALID = 1'b0;
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 10, 16'b1101001010, 80, -1, "after_rst");

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 799) != 0);
      DATA_VALID = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        P_DATA   = DW'($urandom);
        prescale = 6'($urandom_range(0, 10));
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
      end
    end
    rst = 1'b1;
    DATA_VALID = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
